// File: rtl/mpu_i2c_slave_if.sv
// Host-side port of the MPU6050 I2C target: register-file update strobe
// toward the target plus busy / write-report status back to the host.
interface mpu_i2c_slave_if;
  logic       upd_valid;
  logic [6:0] upd_addr;
  logic [7:0] upd_data;
  logic       busy;
  logic       wr_strobe;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  modport master (
    output upd_valid, upd_addr, upd_data,
    input  busy, wr_strobe, wr_addr, wr_data
  );

  modport slave (
    input  upd_valid, upd_addr, upd_data,
    output busy, wr_strobe, wr_addr, wr_data
  );
endinterface

// File: rtl/mpu_i2c_slave.sv
// MPU6050-style I2C target: START/STOP decode, 7-bit address match,
// register-pointer writes and auto-incrementing burst reads over a 128-byte
// register file that the host can refresh through the update port.
// scl/sda stay plain module ports so the open-drain driver sits at the pin.
module mpu_i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h68,
  parameter logic [7:0] PWR_RST    = 8'h40
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            scl,
  inout  wire             sda,
  mpu_i2c_slave_if.slave  bus
);

  localparam logic [6:0] WHO_AM_I_ADDR = 7'h75;
  localparam logic [6:0] PWR_MGMT_ADDR = 7'h6B;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] sr;
  logic [6:0] ptr;
  logic       rw;
  logic       ack_ph;
  logic       sda_oe;

  logic scl_meta, scl_s, scl_d;
  logic sda_meta, sda_s, sda_d;

  logic [7:0] regs [128];

  logic       scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] rx_byte;
  logic [6:0] ptr_inc;
  logic [7:0] cur_rd, next_rd;
  logic       i2c_we;

  // Open drain: only ever pull low or release.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Two-stage synchronizers plus one history stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta <= 1'b1;
      scl_s    <= 1'b1;
      scl_d    <= 1'b1;
      sda_meta <= 1'b1;
      sda_s    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_meta <= scl;
      scl_s    <= scl_meta;
      scl_d    <= scl_s;
      sda_meta <= sda;
      sda_s    <= sda_meta;
      sda_d    <= sda_s;
    end
  end

  // Bus events and register-file read ports.
  always_comb begin
    scl_rise = scl_s & ~scl_d;
    scl_fall = ~scl_s & scl_d;
    start_c  = scl_s & scl_d & sda_d & ~sda_s;
    stop_c   = scl_s & scl_d & ~sda_d & sda_s;
    rx_byte  = {sr[6:0], sda_s};
    ptr_inc  = ptr + 7'd1;
    cur_rd   = regs[ptr];
    next_rd  = regs[ptr_inc];
    i2c_we   = (state == WDATA) && scl_rise && (bit_cnt == 3'd7);
  end

  // Register file: I2C write first so a same-address host update overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 128; i++) regs[i] <= '0;
      regs[PWR_MGMT_ADDR] <= PWR_RST;
      regs[WHO_AM_I_ADDR] <= {1'b0, SLAVE_ADDR};
    end else begin
      if (i2c_we && ptr != WHO_AM_I_ADDR) regs[ptr] <= rx_byte;
      if (bus.upd_valid && bus.upd_addr != WHO_AM_I_ADDR)
        regs[bus.upd_addr] <= bus.upd_data;
    end
  end

  // Protocol FSM; ack_ph separates the fall that opens an ACK slot from the
  // fall that closes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      sr            <= '0;
      ptr           <= '0;
      rw            <= 1'b0;
      ack_ph        <= 1'b0;
      sda_oe        <= 1'b0;
      bus.busy      <= 1'b0;
      bus.wr_strobe <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
    end else begin
      bus.wr_strobe <= 1'b0;
      if (start_c || stop_c) begin
        state    <= start_c ? ADDR : IDLE;
        bit_cnt  <= '0;
        sda_oe   <= 1'b0;
        ack_ph   <= 1'b0;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: if (scl_rise) begin
            sr      <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state  <= ADDR_ACK;
                rw     <= rx_byte[0];
                ack_ph <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_ph) begin
                sda_oe   <= 1'b1;
                bus.busy <= 1'b1;
                ack_ph   <= 1'b1;
              end else begin
                ack_ph  <= 1'b0;
                bit_cnt <= '0;
                if (rw) begin
                  sda_oe <= ~sr[7];
                  state  <= RDATA;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= PTR;
                end
              end
            end else if (scl_rise && ack_ph && rw) begin
              sr <= cur_rd;
            end
          end
          PTR: if (scl_rise) begin
            sr      <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr    <= rx_byte[6:0];
              state  <= PTR_ACK;
              ack_ph <= 1'b0;
            end
          end
          PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (!ack_ph) begin
              sda_oe <= 1'b1;
              ack_ph <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              ack_ph  <= 1'b0;
              bit_cnt <= '0;
              state   <= WDATA;
            end
          end
          WDATA: if (scl_rise) begin
            sr      <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bus.wr_strobe <= 1'b1;
              bus.wr_addr   <= ptr;
              bus.wr_data   <= rx_byte;
              ptr           <= ptr_inc;
              state         <= WDATA_ACK;
              ack_ph        <= 1'b0;
            end
          end
          RDATA: begin
            if (scl_fall) begin
              sr     <= {sr[6:0], 1'b0};
              sda_oe <= ~sr[6];
            end else if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state  <= RDATA_ACK;
                ack_ph <= 1'b0;
              end
            end
          end
          RDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_ph) begin
                sda_oe <= 1'b0;
                ack_ph <= 1'b1;
              end else begin
                sda_oe  <= ~sr[7];
                ack_ph  <= 1'b0;
                bit_cnt <= '0;
                state   <= RDATA;
              end
            end else if (scl_rise && ack_ph) begin
              if (sda_s) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
                ack_ph   <= 1'b0;
              end else begin
                ptr <= ptr_inc;
                sr  <= next_rd;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpu_i2c_slave.sv
// Bench for mpu_i2c_slave: bit-banged I2C master, host update driver and a
// register-file/pointer model of the MPU6050 target.
module tb_mpu_i2c_slave;

  localparam int Q = 5;   // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst_n;
  logic scl;
  logic m_low;
  wire  sda;

  always #10 clk = ~clk;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup pu_sda (sda);

  mpu_i2c_slave_if bus ();

  mpu_i2c_slave dut (
    .clk   (clk),
    .rst_n (rst_n),
    .scl   (scl),
    .sda   (sda),
    .bus   (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [7:0]  mreg [128];
  logic [6:0]  mptr;
  logic [7:0]  wbuf [16];
  logic [14:0] wr_log [$];

  always @(negedge clk)
    if (bus.wr_strobe) wr_log.push_back({bus.wr_addr, bus.wr_data});

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) mreg[i] = 8'h00;
    mreg[7'h6B] = 8'h40;
    mptr = 7'h00;
  endtask

  function automatic logic [7:0] m_rd(input logic [6:0] a);
    return (a == 7'h75) ? 8'h68 : mreg[a];
  endfunction

  task automatic q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; q();
    scl = 1'b1;   q();
    m_low = 1'b1; q();
    scl = 1'b0;   q();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; q();
    scl = 1'b1;   q();
    m_low = 1'b0; q();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i]; q();
      scl = 1'b1; q(); q();
      scl = 1'b0; q();
    end
    m_low = 1'b0; q();
    scl = 1'b1; q();
    ack = (sda === 1'b0);
    q();
    scl = 1'b0; q();
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    b = '0;
    m_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      q();
      scl = 1'b1; q();
      b = {b[6:0], sda};
      q();
      scl = 1'b0;
    end
    q();
    m_low = ~nack; q();
    scl = 1'b1; q(); q();
    scl = 1'b0; q();
    m_low = 1'b0;
  endtask

  task automatic upd(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.upd_valid = 1'b1;
    bus.upd_addr  = a;
    bus.upd_data  = d;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    if (a != 7'h75) mreg[a] = d;
  endtask

  task automatic t_write(input logic [6:0] p, input int n, input logic b7);
    logic ack;
    logic [14:0] exp_q [$];
    wr_log.delete();
    i2c_start();
    wr_byte(8'hD0, ack);
    chk("wr_addr_ack", ack, 1);
    chk("wr_busy_after_match", bus.busy, 1);
    wr_byte({b7, p}, ack);
    chk("wr_ptr_ack", ack, 1);
    mptr = p;
    for (int i = 0; i < n; i++) begin
      wr_byte(wbuf[i], ack);
      chk("wr_data_ack", ack, 1);
      exp_q.push_back({mptr, wbuf[i]});
      if (mptr != 7'h75) mreg[mptr] = wbuf[i];
      mptr = mptr + 7'd1;
    end
    i2c_stop();
    chk("wr_busy_after_stop", bus.busy, 0);
    chk("wr_strobe_count", wr_log.size(), n);
    for (int i = 0; i < n && i < wr_log.size(); i++)
      chk("wr_strobe_entry", wr_log[i], exp_q[i]);
    wr_log.delete();
  endtask

  task automatic rd_body(input int n);
    logic ack;
    logic [7:0] b;
    wr_byte(8'hD1, ack);
    chk("rd_addr_ack", ack, 1);
    chk("rd_busy_after_match", bus.busy, 1);
    for (int i = 0; i < n; i++) begin
      rd_byte(i == n - 1, b);
      chk("rd_data", b, m_rd(mptr));
      if (i != n - 1) mptr = mptr + 7'd1;
    end
    chk("rd_sda_released_after_nack", sda, 1);
    chk("rd_busy_after_nack", bus.busy, 0);
  endtask

  task automatic t_read(input logic [6:0] p, input int n, input logic b7);
    logic ack;
    i2c_start();
    wr_byte(8'hD0, ack);
    chk("rdp_addr_ack", ack, 1);
    wr_byte({b7, p}, ack);
    chk("rdp_ptr_ack", ack, 1);
    mptr = p;
    i2c_start();
    rd_body(n);
    i2c_stop();
    chk("rd_busy_after_stop", bus.busy, 0);
  endtask

  task automatic t_read_cur(input int n);
    i2c_start();
    rd_body(n);
    i2c_stop();
    chk("rdc_busy_after_stop", bus.busy, 0);
  endtask

  initial begin
    logic ack;
    int   op;
    bus.upd_valid = 1'b0;
    bus.upd_addr  = '0;
    bus.upd_data  = '0;
    scl   = 1'b1;
    m_low = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    q();

    chk("reset_sda", sda, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_wr_strobe", bus.wr_strobe, 0);
    chk("reset_wr_addr", bus.wr_addr, 0);
    chk("reset_wr_data", bus.wr_data, 0);

    // WHO_AM_I read
    t_read(7'h75, 1, 1'b0);

    // Wake-up write and read-back
    wbuf[0] = 8'h00;
    t_write(7'h6B, 1, 1'b0);
    t_read(7'h6B, 1, 1'b0);

    // Host-loaded sensor block, 14-byte burst read
    for (int i = 0; i < 14; i++) upd(7'(7'h3B + i), 8'(8'h10 + i));
    t_read(7'h3B, 14, 1'b0);

    // Foreign address: no ACK, trailing bytes ignored
    wr_log.delete();
    i2c_start();
    wr_byte(8'hD2, ack);
    chk("foreign_no_ack", ack, 0);
    chk("foreign_busy", bus.busy, 0);
    wr_byte(8'h6B, ack);
    chk("foreign_byte1_no_ack", ack, 0);
    wr_byte(8'h77, ack);
    chk("foreign_byte2_no_ack", ack, 0);
    i2c_stop();
    chk("foreign_no_strobe", wr_log.size(), 0);
    t_read(7'h6B, 1, 1'b1);

    // Pointer wrap on write and read
    wbuf[0] = 8'hAA;
    wbuf[1] = 8'hBB;
    t_write(7'h7F, 2, 1'b0);
    t_read(7'h7F, 2, 1'b0);

    // WHO_AM_I is read-only
    wbuf[0] = 8'h55;
    t_write(7'h75, 1, 1'b0);
    t_read(7'h75, 1, 1'b0);

    // Randomized mix of host updates, writes and reads
    for (int it = 0; it < 20; it++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: upd(7'($urandom_range(0, 127)), 8'($urandom));
        1: begin
          for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
          t_write(7'($urandom_range(0, 127)), int'($urandom_range(1, 3)), 1'($urandom));
        end
        2: t_read(7'($urandom_range(0, 127)), int'($urandom_range(1, 4)), 1'($urandom));
        default: t_read_cur(int'($urandom_range(1, 3)));
      endcase
    end

    // Reset while the target pulls sda low for read bit 7
    wbuf[0] = 8'h00;
    t_write(7'h6B, 1, 1'b0);
    i2c_start();
    wr_byte(8'hD0, ack);
    wr_byte(8'h6B, ack);
    i2c_start();
    wr_byte(8'hD1, ack);
    chk("midread_addr_ack", ack, 1);
    chk("midread_sda_driven", sda, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midread_sda_released", sda, 1);
    chk("midread_busy", bus.busy, 0);
    scl = 1'b1;
    q();
    rst_n = 1'b1;
    q();
    model_reset();
    chk("postreset_wr_addr", bus.wr_addr, 0);
    t_read(7'h6B, 1, 1'b0);
    t_read(7'h3B, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
